// File: rtl/eth_tx_arb_2.sv
// Two-requester round-robin frame arbiter feeding one MAC tx AXI-stream port.
// Grant is held for a whole frame; pause_req stops new grants between frames.
module eth_tx_arb_2 #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned USER_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
   input  logic                  s0_axis_tvalid,
   output logic                  s0_axis_tready,
   input  logic                  s0_axis_tlast,
   input  logic [USER_WIDTH-1:0] s0_axis_tuser,

   input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
   input  logic                  s1_axis_tvalid,
   output logic                  s1_axis_tready,
   input  logic                  s1_axis_tlast,
   input  logic [USER_WIDTH-1:0] s1_axis_tuser,

   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,

   input  logic                  pause_req,
   output logic                  pause_ack,
   output logic [1:0]            grant
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] grant_nxt;
   logic       ptr;
   logic       ptr_nxt;
   logic       pause_ack_nxt;
   logic       sel;
   logic       last_xfer;

   assign sel       = grant[1];
   assign last_xfer = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // Granted requester is steered straight onto the master port.
   always_comb begin
      m_axis_tdata   = '0;
      m_axis_tkeep   = '0;
      m_axis_tvalid  = 1'b0;
      m_axis_tlast   = 1'b0;
      m_axis_tuser   = '0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      if (state == ACTIVE) begin
         if (sel) begin
            m_axis_tdata   = s1_axis_tdata;
            m_axis_tkeep   = s1_axis_tkeep;
            m_axis_tvalid  = s1_axis_tvalid;
            m_axis_tlast   = s1_axis_tlast;
            m_axis_tuser   = s1_axis_tuser;
            s1_axis_tready = m_axis_tready;
         end else begin
            m_axis_tdata   = s0_axis_tdata;
            m_axis_tkeep   = s0_axis_tkeep;
            m_axis_tvalid  = s0_axis_tvalid;
            m_axis_tlast   = s0_axis_tlast;
            m_axis_tuser   = s0_axis_tuser;
            s0_axis_tready = m_axis_tready;
         end
      end
   end

   // Next-state: arbitrate in IDLE, release on the tlast handshake.
   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      ptr_nxt       = ptr;
      pause_ack_nxt = pause_ack;

      if (!pause_req) begin
         pause_ack_nxt = 1'b0;
      end else if (state == IDLE) begin
         pause_ack_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            if (!pause_req && (s0_axis_tvalid || s1_axis_tvalid)) begin
               state_nxt = ACTIVE;
               // ptr holds the last-served port; the other one wins a tie.
               if (s0_axis_tvalid && (!s1_axis_tvalid || ptr)) begin
                  grant_nxt = 2'b01;
               end else begin
                  grant_nxt = 2'b10;
               end
            end
         end
         ACTIVE: begin
            if (last_xfer) begin
               state_nxt = IDLE;
               grant_nxt = 2'b00;
               ptr_nxt   = sel;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= 2'b00;
         ptr       <= 1'b1;
         pause_ack <= 1'b0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         ptr       <= ptr_nxt;
         pause_ack <= pause_ack_nxt;
      end
   end

endmodule

// File: tb/tb_eth_tx_arb_2.sv
// Scoreboard bench for eth_tx_arb_2: per-port source drivers, an output monitor
// that pops expected beats, and directed checks on grant/tready/pause_ack timing.
module tb_eth_tx_arb_2;

   localparam int unsigned DW = 64;
   localparam int unsigned KW = 8;
   localparam int unsigned UW = 1;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [UW-1:0] user;
      logic          port;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s0_axis_tdata = '0, s1_axis_tdata = '0;
   logic [KW-1:0] s0_axis_tkeep = '0, s1_axis_tkeep = '0;
   logic          s0_axis_tvalid = 1'b0, s1_axis_tvalid = 1'b0;
   logic          s0_axis_tready, s1_axis_tready;
   logic          s0_axis_tlast = 1'b0, s1_axis_tlast = 1'b0;
   logic [UW-1:0] s0_axis_tuser = '0, s1_axis_tuser = '0;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic          m_axis_tlast;
   logic [UW-1:0] m_axis_tuser;
   logic          pause_req = 1'b0;
   logic          pause_ack;
   logic [1:0]    grant;

   int    total = 0;
   int    bad   = 0;
   beat_t dq0[$];
   beat_t dq1[$];
   beat_t exp_q[$];
   logic  flush   = 1'b0;
   logic  gap_chk = 1'b0;

   eth_tx_arb_2 #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
      .clk(clk), .rst(rst),
      .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
      .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
      .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser),
      .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
      .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
      .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .pause_req(pause_req), .pause_ack(pause_ack), .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s act=0x%0h exp=0x%0h", name, act, expv);
      end
   endtask

   task automatic tmo(input string name);
      total++;
      bad++;
      $display("FAIL %s timeout waiting", name);
   endtask

   // Queue a frame on a source; only the first nexp beats are expected at the output.
   task automatic add_frame(input logic p, input int fid, input int n, input int nexp);
      beat_t bt;
      for (int b = 0; b < n; b++) begin
         bt.data = (64'(p) << 32) | (64'(fid) << 16) | 64'(b);
         bt.keep = 8'(b + 1);
         bt.last = (b == n - 1);
         bt.user = 1'(b);
         bt.port = p;
         if (p) dq1.push_back(bt);
         else   dq0.push_back(bt);
         if (b < nexp) exp_q.push_back(bt);
      end
   endtask

   task automatic drive_step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_last(input string name);
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) done = 1;
      end
      if (!done) tmo(name);
   endtask

   task automatic wait_grant(input string name, input logic [1:0] g);
      bit done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (grant == g) done = 1;
      end
      if (!done) tmo(name);
   endtask

   // One-cycle reset pulse; sources abandon whatever they were sending.
   task automatic pulse_reset();
      rst = 1'b1;
      m_axis_tready = 1'b0;
      flush = 1'b1;
      drive_step();
      rst = 1'b0;
      flush = 1'b0;
      m_axis_tready = 1'b1;
   endtask

   // Source 0 driver: advance on the handshake seen just before the edge.
   initial begin
      logic hs;
      forever begin
         @(negedge clk);
         hs = s0_axis_tvalid && s0_axis_tready;
         @(posedge clk);
         #1;
         if (flush) dq0.delete();
         else if (hs && dq0.size() > 0) void'(dq0.pop_front());
         if (dq0.size() > 0) begin
            s0_axis_tdata  = dq0[0].data;
            s0_axis_tkeep  = dq0[0].keep;
            s0_axis_tlast  = dq0[0].last;
            s0_axis_tuser  = dq0[0].user;
            s0_axis_tvalid = 1'b1;
         end else begin
            s0_axis_tvalid = 1'b0;
         end
      end
   end

   // Source 1 driver.
   initial begin
      logic hs;
      forever begin
         @(negedge clk);
         hs = s1_axis_tvalid && s1_axis_tready;
         @(posedge clk);
         #1;
         if (flush) dq1.delete();
         else if (hs && dq1.size() > 0) void'(dq1.pop_front());
         if (dq1.size() > 0) begin
            s1_axis_tdata  = dq1[0].data;
            s1_axis_tkeep  = dq1[0].keep;
            s1_axis_tlast  = dq1[0].last;
            s1_axis_tuser  = dq1[0].user;
            s1_axis_tvalid = 1'b1;
         end else begin
            s1_axis_tvalid = 1'b0;
         end
      end
   end

   // Monitor: every output handshake must match the head of the scoreboard.
   initial begin
      int    cyc = 0;
      int    last_cyc = 0;
      bit    have_last = 0;
      bit    in_frame = 0;
      beat_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!gap_chk) have_last = 0;
         if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL beat unexpected data=0x%0h grant=%b", m_axis_tdata, grant);
            end else begin
               e = exp_q.pop_front();
               check("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, grant},
                     {e.data, e.keep, e.last, e.user, (e.port ? 2'b10 : 2'b01)});
            end
            if (!in_frame && gap_chk && have_last)
               check("frame_gap", 128'(cyc - last_cyc), 128'(2));
            in_frame = !m_axis_tlast;
            if (m_axis_tlast) begin
               last_cyc  = cyc;
               have_last = 1;
            end
         end
         if (rst) in_frame = 0;
      end
   end

   initial begin
      logic [3:0] pat = 4'b1001;
      int         k   = 0;
      bit         done;

      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("rst_grant", 128'(grant), 128'(0));
      check("rst_pause_ack", 128'(pause_ack), 128'(0));
      check("rst_tready", 128'({s0_axis_tready, s1_axis_tready}), 128'(0));
      check("rst_mvalid", 128'(m_axis_tvalid), 128'(0));

      // Single 3-beat s0 frame: one-cycle arbitration latency, grant clears after tlast.
      add_frame(1'b0, 1, 3, 3);
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (s0_axis_tvalid) done = 1;
      end
      if (!done) tmo("s0_valid");
      check("idle_grant", 128'(grant), 128'(0));
      check("idle_tready0", 128'(s0_axis_tready), 128'(0));
      @(negedge clk);
      check("grant_s0", 128'(grant), 128'(2'b01));
      wait_last("single_last");
      @(negedge clk);
      check("grant_clear", 128'(grant), 128'(0));
      check("mvalid_clear", 128'(m_axis_tvalid), 128'(0));

      // Alternation from reset with one idle cycle between frames.
      drive_step();
      pulse_reset();
      gap_chk = 1'b1;
      for (int r = 0; r < 4; r++) begin
         add_frame(1'b0, 16 + r, 2, 2);
         add_frame(1'b1, 16 + r, 2, 2);
      end
      for (int f = 0; f < 8; f++) wait_last("rr_last");
      gap_chk = 1'b0;

      // Backpressure on an 8-beat s1 frame.
      drive_step();
      add_frame(1'b1, 32, 8, 8);
      done = 0;
      for (int i = 0; i < 80 && !done; i++) begin
         @(negedge clk);
         if (grant == 2'b10) begin
            check("bp_s1_tready", 128'(s1_axis_tready), 128'(m_axis_tready));
            check("bp_s0_tready", 128'(s0_axis_tready), 128'(0));
         end
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) done = 1;
         else begin
            drive_step();
            m_axis_tready = pat[k % 4];
            k++;
         end
      end
      if (!done) tmo("bp_last");
      drive_step();
      m_axis_tready = 1'b1;

      // Pause during an s0 frame with s1 pending.
      add_frame(1'b0, 48, 4, 4);
      wait_grant("pause_grant_s0", 2'b01);
      drive_step();
      pause_req = 1'b1;
      add_frame(1'b1, 48, 2, 2);
      wait_last("pause_s0_last");
      @(negedge clk);
      check("pause_idle_grant", 128'(grant), 128'(0));
      check("pause_ack_lag", 128'(pause_ack), 128'(0));
      @(negedge clk);
      check("pause_ack_set", 128'(pause_ack), 128'(1));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("paused_grant", 128'({grant, s1_axis_tready}), 128'(0));
      end
      drive_step();
      pause_req = 1'b0;
      @(negedge clk);
      check("unpause_grant_pre", 128'({grant, pause_ack}), 128'({2'b00, 1'b1}));
      @(negedge clk);
      check("unpause_grant", 128'({grant, pause_ack}), 128'({2'b10, 1'b0}));
      wait_last("unpause_s1_last");

      // Reset mid-frame abandons the frame; next tie goes to s0.
      drive_step();
      add_frame(1'b0, 64, 6, 2);
      wait_grant("rst_frame_grant", 2'b01);
      drive_step();
      @(negedge clk);
      drive_step();
      pulse_reset();
      @(negedge clk);
      check("midrst_grant", 128'(grant), 128'(0));
      check("midrst_tready", 128'({s0_axis_tready, s1_axis_tready}), 128'(0));
      check("midrst_mvalid", 128'(m_axis_tvalid), 128'(0));
      check("midrst_pause_ack", 128'(pause_ack), 128'(0));
      add_frame(1'b0, 80, 2, 2);
      add_frame(1'b1, 80, 2, 2);
      wait_last("tie_first");
      wait_last("tie_second");
      repeat (3) @(negedge clk);
      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
